// File: rtl/btn_debounce_pulse.sv
// Pushbutton front end: 2-flop synchronizer, ms-tick debouncer and registered
// press / release / long-press single-cycle pulses.
module btn_debounce_pulse #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned SIM_MODE    = 0,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned TickPeriod = (SIM_MODE != 0) ? 10 : TICK_DIV;
    localparam int unsigned TickW      = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;
    localparam int unsigned MsW        = (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;

    if (DEBOUNCE_MS < 1 || LONG_MS < 1 || TICK_DIV < 2) begin : g_param_check
        $error("btn_debounce_pulse: need DEBOUNCE_MS>=1, LONG_MS>=1, TICK_DIV>=2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StPressed,
        StLong,
        StReleaseWait
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, btn_s_q;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [MsW-1:0]   ms_cnt_q, ms_cnt_d;
    logic             long_flag_q, long_flag_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             tick;
    logic             debounce_done;
    logic             long_done;

    assign tick          = (tick_cnt_q == TickW'(TickPeriod - 1));
    assign debounce_done = tick && (32'(ms_cnt_q) == DEBOUNCE_MS - 1);
    assign long_done     = tick && (32'(ms_cnt_q) == LONG_MS - 1);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end

    always_comb begin
        state_d     = state_q;
        long_flag_d = long_flag_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        // A btn_s change always takes priority over a tick in the same cycle.
        unique case (state_q)
            StIdle: begin
                if (btn_s_q) state_d = StPressWait;
            end
            StPressWait: begin
                if (!btn_s_q) begin
                    state_d = StIdle;
                end else if (debounce_done) begin
                    state_d = StPressed;
                    press_d = 1'b1;
                end
            end
            StPressed: begin
                if (!btn_s_q) begin
                    state_d = StReleaseWait;
                end else if (long_done) begin
                    state_d     = StLong;
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                end
            end
            StLong: begin
                if (!btn_s_q) state_d = StReleaseWait;
            end
            StReleaseWait: begin
                if (btn_s_q) begin
                    state_d = long_flag_q ? StLong : StPressed;
                end else if (debounce_done) begin
                    state_d     = StIdle;
                    release_d   = 1'b1;
                    long_flag_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        level_d = (state_d == StPressed) || (state_d == StLong) ||
                  (state_d == StReleaseWait);
    end

    // ms_cnt restarts on every state entry and saturates rather than wrapping.
    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (state_d != state_q) begin
            ms_cnt_d = '0;
        end else if (tick && (ms_cnt_q != {MsW{1'b1}})) begin
            ms_cnt_d = ms_cnt_q + MsW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            tick_cnt_q  <= '0;
            ms_cnt_q    <= '0;
            state_q     <= StIdle;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            btn_s_q     <= sync1_q;
            tick_cnt_q  <= tick_cnt_d;
            ms_cnt_q    <= ms_cnt_d;
            state_q     <= state_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse in SIM_MODE (10-clk tick, 20 ms debounce,
// 100 ms long press).
module tb_btn_debounce_pulse;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    btn_debounce_pulse #(
        .TICK_DIV   (100000),
        .SIM_MODE   (1),
        .DEBOUNCE_MS(20),
        .LONG_MS    (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int press_cnt = 0, release_cnt = 0, long_cnt = 0, rise_cnt = 0, overlap_cnt = 0;
    int press_cyc = 0, release_cyc = 0, long_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    logic prev_level = 1'b0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cyc is the index of the edge that produced it.
    always @(negedge clk) begin
        if (press_pulse === 1'b1) begin
            press_cnt++;
            press_cyc = cyc;
        end
        if (release_pulse === 1'b1) begin
            release_cnt++;
            release_cyc = cyc;
        end
        if (long_pulse === 1'b1) begin
            long_cnt++;
            long_cyc = cyc;
        end
        if ((int'(press_pulse === 1'b1) + int'(release_pulse === 1'b1) +
             int'(long_pulse === 1'b1)) > 1) overlap_cnt++;
        if (btn_level === 1'b1 && prev_level !== 1'b1) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (btn_level !== 1'b1 && prev_level === 1'b1) fall_cyc = cyc;
        prev_level = btn_level;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    int p0, r0, l0, rise0, edge_cyc, d;

    initial begin
        // 1: reset and idle
        clks(5);
        rst = 1'b0;
        settle();
        check("rst_level", 32'(btn_level), 0);
        check("rst_press", 32'(press_pulse), 0);
        check("rst_release", 32'(release_pulse), 0);
        check("rst_long", 32'(long_pulse), 0);
        clks(500);
        settle();
        check("idle_pulses", 32'(press_cnt + release_cnt + long_cnt), 0);

        // 2: 150-clk bounce is rejected
        clks(1);
        btn_raw = 1'b1;
        clks(150);
        btn_raw = 1'b0;
        clks(60);
        settle();
        check("bounce_press", 32'(press_cnt), 0);
        check("bounce_rise", 32'(rise_cnt), 0);
        check("bounce_level", 32'(btn_level), 0);

        // 3: accepted press, no long
        clks(1);
        p0 = press_cnt; l0 = long_cnt;
        edge_cyc = cyc;
        btn_raw = 1'b1;
        clks(400);
        settle();
        check("press_count", 32'(press_cnt - p0), 1);
        d = press_cyc - edge_cyc;
        check("press_latency_ok", 32'(d >= 191 && d <= 203), 1);
        check("press_level_same_cyc", 32'(rise_cyc), 32'(press_cyc));
        check("press_no_long", 32'(long_cnt - l0), 0);
        check("press_level", 32'(btn_level), 1);

        // 5: short low glitch while PRESSED, then real release
        clks(1);
        r0 = release_cnt;
        btn_raw = 1'b0;
        clks(50);
        btn_raw = 1'b1;
        clks(100);
        settle();
        check("glitch_no_release", 32'(release_cnt - r0), 0);
        check("glitch_level", 32'(btn_level), 1);
        clks(1);
        edge_cyc = cyc;
        btn_raw = 1'b0;
        clks(300);
        settle();
        check("release_count", 32'(release_cnt - r0), 1);
        d = release_cyc - edge_cyc;
        check("release_latency_ok", 32'(d >= 191 && d <= 203), 1);
        check("release_fall_same_cyc", 32'(fall_cyc), 32'(release_cyc));
        check("release_level", 32'(btn_level), 0);

        // 4: long press
        clks(1);
        p0 = press_cnt; l0 = long_cnt;
        btn_raw = 1'b1;
        clks(1300);
        settle();
        check("long_press_count", 32'(press_cnt - p0), 1);
        check("long_count", 32'(long_cnt - l0), 1);
        d = long_cyc - press_cyc;
        check("long_latency_ok", 32'(d >= 990 && d <= 1010), 1);
        check("long_level", 32'(btn_level), 1);

        // Glitch while LONG must return to LONG without a second long_pulse
        clks(1);
        r0 = release_cnt;
        btn_raw = 1'b0;
        clks(50);
        btn_raw = 1'b1;
        clks(1200);
        settle();
        check("long_glitch_no_release", 32'(release_cnt - r0), 0);
        check("long_glitch_no_relong", 32'(long_cnt - l0), 1);
        check("long_glitch_level", 32'(btn_level), 1);

        // 6: reset while LONG with button still held
        clks(1);
        p0 = press_cnt; r0 = release_cnt; rise0 = rise_cnt;
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        edge_cyc = cyc;
        settle();
        check("mid_rst_level", 32'(btn_level), 0);
        check("mid_rst_press", 32'(press_pulse), 0);
        clks(260);
        settle();
        check("mid_rst_no_release", 32'(release_cnt - r0), 0);
        check("mid_rst_repress", 32'(press_cnt - p0), 1);
        d = press_cyc - edge_cyc;
        check("mid_rst_repress_lat_ok", 32'(d >= 191 && d <= 205), 1);
        check("mid_rst_rise", 32'(rise_cnt - rise0), 1);

        check("no_overlap", 32'(overlap_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
